// File: rtl/frame_pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
//   Shared definitions for the frame pulse timing engine:
//   - state_e      : timing FSM states (IDLE, DELAY, PULSE)
//   - *_W_DEF      : default widths for the delay/duration counters, the
//                    frame counter and the missed-trigger counter
//   - SYNC_STAGES  : number of metastability flops on the trigger input
//   - DEL_BASE..   : frame-register RAM word indices feeding this block
// ---------------------------------------------------------------------------
package frame_pkg;

  // Default widths. The CNT/FCNT/MCNT names are taken by the top-level
  // parameters, so the package defaults carry a _DEF suffix.
  localparam int CNT_W_DEF  = 32;
  localparam int FCNT_W_DEF = 16;
  localparam int MCNT_W_DEF = 8;

  // Two metastability flops ahead of the edge-detect history flop.
  localparam int SYNC_STAGES = 2;

  // Register map word indices (byte-wide words in the frame-register RAM).
  localparam int DEL_BASE = 0;  // words 0..3 : delay, little-endian
  localparam int DUR_BASE = 4;  // words 4..7 : duration, little-endian
  localparam int THHV_IDX = 8;  // word 8     : HV ready threshold
  localparam int RES_IDX  = 9;  // word 9     : reserved

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_e;

endpackage

// File: rtl/frame_pulse_gen_trig_sync_edge.sv
// ---------------------------------------------------------------------------
// trig_sync_edge
//   Brings the asynchronous external trigger into the clk domain through a
//   SYNC_STAGES-deep flop chain, keeps one extra history flop and reports a
//   single-cycle rising-edge pulse.
//
//   Ports:
//     clk       in   system clock
//     clr       in   synchronous active-high reset (clears the whole chain)
//     trig_in   in   asynchronous trigger
//     trig_edge out  high for one cycle after a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module trig_sync_edge
  import frame_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic trig_in,
  output logic trig_edge
);

  localparam int CHAIN_LEN = SYNC_STAGES + 1;

  logic [CHAIN_LEN-1:0] s_q;
  logic [CHAIN_LEN-1:0] s_d;

  assign s_d[0] = trig_in;

  genvar gi;
  generate
    for (gi = 1; gi < CHAIN_LEN; gi++) begin : g_chain
      assign s_d[gi] = s_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  // Last synchronised sample high, history flop still low.
  assign trig_edge = s_q[SYNC_STAGES-1] & ~s_q[SYNC_STAGES];

endmodule

// File: rtl/frame_pulse_gen.sv
// ---------------------------------------------------------------------------
// frame_pulse_gen
//   Timing engine behind the frame-register RAM. Each accepted trigger waits
//   `del` clocks, then holds the frame/exposure pulse high for `dur` clocks.
//   A trigger is accepted only in IDLE with en=1, hv_level >= thhv and a
//   non-zero duration; every other trigger seen while enabled or busy is
//   counted as a miss.
//
//   Ports:
//     clk        in   system clock
//     clr        in   synchronous active-high reset
//     en         in   global enable; dropping it while busy aborts the pulse
//     trig_in    in   asynchronous external trigger
//     del        in   delay in clocks
//     dur        in   pulse width in clocks
//     thhv       in   HV ready threshold
//     hv_level   in   HV monitor sample (already synchronous to clk)
//     pulse_out  out  registered frame pulse
//     busy       out  high while in DELAY or PULSE
//     done       out  one-cycle strobe after a completed pulse
//     frame_cnt  out  completed pulses, wraps
//     miss_cnt   out  rejected triggers, saturates
// ---------------------------------------------------------------------------
module frame_pulse_gen
  import frame_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FCNT_W = FCNT_W_DEF,
  parameter int MCNT_W = MCNT_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              trig_in,
  input  logic [CNT_W-1:0]  del,
  input  logic [CNT_W-1:0]  dur,
  input  logic [7:0]        thhv,
  input  logic [7:0]        hv_level,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [MCNT_W-1:0] miss_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FCNT_W-1:0] FRAME_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};
  localparam logic [MCNT_W-1:0] MISS_ONE  = {{(MCNT_W-1){1'b0}}, 1'b1};
  localparam logic [MCNT_W-1:0] MISS_MAX  = {MCNT_W{1'b1}};

  // -------------------------------------------------------------------------
  // Trigger conditioning
  // -------------------------------------------------------------------------
  logic trig_edge;

  trig_sync_edge u_trig_sync_edge (
    .clk       (clk),
    .clr       (clr),
    .trig_in   (trig_in),
    .trig_edge (trig_edge)
  );

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;     // down-counter for DELAY and PULSE
  logic [CNT_W-1:0]    dur_sh_q, dur_sh_d;  // duration captured at acceptance
  logic                pulse_q,  pulse_d;
  logic                done_q,   done_d;
  logic [FCNT_W-1:0]   frame_q,  frame_d;
  logic [MCNT_W-1:0]   miss_q,   miss_d;

  logic hv_ok;
  logic dur_nz;
  logic accept;
  logic miss_ev;
  logic cnt_last;

  assign hv_ok    = (hv_level >= thhv);
  assign dur_nz   = (dur != '0);
  assign cnt_last = (cnt_q == CNT_ONE);

  assign accept  = (state_q == IDLE) && trig_edge && en && hv_ok && dur_nz;

  // Any trigger while busy is a miss, even on the edge that returns to IDLE
  // (the state sampled at that edge is still DELAY/PULSE). In IDLE only an
  // enabled trigger that fails the acceptance test counts.
  assign miss_ev = trig_edge &&
                   ((state_q != IDLE) || (en && !(hv_ok && dur_nz)));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dur_sh_q <= '0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      frame_q  <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dur_sh_q <= dur_sh_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      frame_q  <= frame_d;
      miss_q   <= miss_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // The delay needs no separate shadow: it is copied straight into cnt_q at
  // acceptance, so a later write to `del` cannot reach the pulse in flight.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dur_sh_d = dur_sh_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dur_sh_d = dur;
          if (del != '0) begin
            state_d = DELAY;
            cnt_d   = del;
          end else begin
            state_d = PULSE;
            cnt_d   = dur;
          end
        end
      end

      DELAY: begin
        if (!en) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          state_d = PULSE;
          cnt_d   = dur_sh_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      PULSE: begin
        if (!en || cnt_last) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Registering (next state == PULSE) makes pulse_out track the state
    // exactly, with no combinational path to the pin.
    pulse_d = (state_d == PULSE);

    // Only a natural end of PULSE completes a frame; an en abort does not.
    done_d = (state_q == PULSE) && en && cnt_last;

    frame_d = frame_q;
    if (done_d) begin
      frame_d = frame_q + FRAME_ONE;
    end

    miss_d = miss_q;
    if (miss_ev && (miss_q != MISS_MAX)) begin
      miss_d = miss_q + MISS_ONE;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign frame_cnt = frame_q;
  assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_frame_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_frame_pulse_gen
//   Self-checking bench for frame_pulse_gen. A reference model tracks each
//   trigger as an event: its acceptance edge, the edge the pulse rises and
//   the edge it falls, all computed from del/dur with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_frame_pulse_gen;

  localparam int CW = 32;
  localparam int FW = 10;
  localparam int MW = 8;
  localparam longint FMOD = 64'd1 << FW;
  localparam int MMAX = (1 << MW) - 1;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic           en = 1'b0;
  logic           trig_in = 1'b0;
  logic [CW-1:0]  del = '0;
  logic [CW-1:0]  dur = '0;
  logic [7:0]     thhv = 8'h00;
  logic [7:0]     hv_level = 8'h00;
  logic           pulse_out;
  logic           busy;
  logic           done;
  logic [FW-1:0]  frame_cnt;
  logic [MW-1:0]  miss_cnt;

  frame_pulse_gen #(
    .CNT_W  (CW),
    .FCNT_W (FW),
    .MCNT_W (MW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .trig_in   (trig_in),
    .del       (del),
    .dur       (dur),
    .thhv      (thhv),
    .hv_level  (hv_level),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  longint     m = 0;          // index of the most recent clock edge
  logic [3:0] samp = '0;      // trig_in as sampled at edges m, m-1, m-2, m-3
  bit         mod_active = 1'b0;
  longint     acc_e = 0;
  longint     rise_e = 0;
  longint     fall_e = 0;
  longint     frames = 0;
  int         misses = 0;
  bit         done_e = 1'b0;
  int         n_ev = 0;
  int         n_acc = 0;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, m, act_v, exp_v);
    end
  endtask

  // A rising trigger sampled at edge j is acted on at edge j+2.
  task automatic model_edge();
    bit ev;
    bit was_busy;
    m++;
    done_e = 1'b0;
    if (clr === 1'b1) begin
      samp       = '0;
      mod_active = 1'b0;
      frames     = 0;
      misses     = 0;
      return;
    end
    samp     = {samp[2:0], trig_in};
    ev       = samp[2] & ~samp[3];
    was_busy = mod_active && (m > acc_e) && (m <= fall_e);
    if (was_busy && !en) begin
      mod_active = 1'b0;
    end else if (was_busy && m == fall_e) begin
      mod_active = 1'b0;
      frames++;
      done_e = 1'b1;
    end
    if (ev) begin
      n_ev++;
      if (was_busy) begin
        if (misses < MMAX) misses++;
      end else if (en) begin
        if (int'(hv_level) >= int'(thhv) && dur != 0) begin
          mod_active = 1'b1;
          acc_e      = m;
          rise_e     = m + longint'({32'b0, del});
          fall_e     = rise_e + longint'({32'b0, dur});
          n_acc++;
        end else begin
          if (misses < MMAX) misses++;
        end
      end
    end
  endtask

  task automatic step();
    bit e_pulse;
    @(posedge clk);
    model_edge();
    #1;
    e_pulse = mod_active && (m >= rise_e) && (m < fall_e);
    chk("pulse_out", 64'(pulse_out), 64'(e_pulse));
    chk("busy",      64'(busy),      64'(mod_active));
    chk("done",      64'(done),      64'(done_e));
    chk("frame_cnt", 64'(frame_cnt), 64'(frames % FMOD));
    chk("miss_cnt",  64'(miss_cnt),  64'(misses));
  endtask

  task automatic do_reset();
    trig_in = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  typedef struct {
    logic [31:0] v_del;
    logic [31:0] v_dur;
    logic [7:0]  v_thhv;
    logic [7:0]  v_hv;
    logic        v_en;
    int          exp_rise;   // edges from trig_in rise to pulse_out rise (0: none)
    int          exp_width;
    int          exp_done;
    int          exp_miss;
    int          exp_busy;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    longint k;
    longint rise;
    int width, dn, bs;
    do_reset();
    del = v.v_del; dur = v.v_dur; thhv = v.v_thhv; hv_level = v.v_hv; en = v.v_en;
    step();
    k = m; trig_in = 1'b1;
    rise = 0; width = 0; dn = 0; bs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      trig_in = 1'b0;
      if (pulse_out === 1'b1) begin
        if (width == 0) rise = m - k;
        width++;
      end
      if (done === 1'b1) dn++;
      if (busy === 1'b1) bs = 1;
    end
    chk($sformatf("vec%0d_rise", idx),  64'(rise),      64'(v.exp_rise));
    chk($sformatf("vec%0d_width", idx), 64'(width),     64'(v.exp_width));
    chk($sformatf("vec%0d_done", idx),  64'(dn),        64'(v.exp_done));
    chk($sformatf("vec%0d_frame", idx), 64'(frame_cnt), 64'(v.exp_done));
    chk($sformatf("vec%0d_miss", idx),  64'(miss_cnt),  64'(v.exp_miss));
    chk($sformatf("vec%0d_busy", idx),  64'(bs),        64'(v.exp_busy));
    $display("vec %0d: del=%0d dur=%0d thhv=%h hv=%h en=%0d -> rise=%0d width=%0d done=%0d miss=%0d",
             idx, v.v_del, v.v_dur, v.v_thhv, v.v_hv, v.v_en, rise, width, dn, miss_cnt);
  endtask

  vec_t vecs[8];

  initial begin
    longint k, rise, fall;
    int dn;

    vecs[0] = '{32'd5, 32'd3, 8'h40, 8'h80, 1'b1, 8, 3, 1, 0, 1};
    vecs[1] = '{32'd0, 32'd1, 8'h40, 8'h80, 1'b1, 3, 1, 1, 0, 1};
    vecs[2] = '{32'd4, 32'd0, 8'h40, 8'h80, 1'b1, 0, 0, 0, 1, 0};
    vecs[3] = '{32'd2, 32'd2, 8'h40, 8'h3F, 1'b1, 0, 0, 0, 1, 0};
    vecs[4] = '{32'd2, 32'd2, 8'h40, 8'h40, 1'b1, 5, 2, 1, 0, 1};
    vecs[5] = '{32'd2, 32'd2, 8'h40, 8'h80, 1'b0, 0, 0, 0, 0, 0};
    vecs[6] = '{32'd1, 32'd4, 8'h00, 8'h00, 1'b1, 4, 4, 1, 0, 1};
    vecs[7] = '{32'd3, 32'd1, 8'hFF, 8'hFF, 1'b1, 6, 1, 1, 0, 1};

    // Reset state
    do_reset();
    chk("reset_pulse", 64'(pulse_out), 64'd0);
    chk("reset_busy",  64'(busy),      64'd0);
    chk("reset_frame", 64'(frame_cnt), 64'd0);
    chk("reset_miss",  64'(miss_cnt),  64'd0);
    $display("reset: pulse=%0d busy=%0d done=%0d frame=%0d miss=%0d",
             pulse_out, busy, done, frame_cnt, miss_cnt);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Retrigger during DELAY plus a del write: timing must stay as latched.
    do_reset();
    del = 10; dur = 10; thhv = 8'h40; hv_level = 8'h80; en = 1'b1;
    step();
    k = m; trig_in = 1'b1; rise = 0; fall = 0;
    for (int i = 0; i < 36; i++) begin
      step();
      if (m == k + 1) trig_in = 1'b0;
      if (m == k + 5) del = 2;
      if (m == k + 8) trig_in = 1'b1;
      if (m == k + 9) trig_in = 1'b0;
      if (pulse_out === 1'b1 && rise == 0) rise = m;
      if (rise != 0 && pulse_out === 1'b0 && fall == 0) fall = m;
    end
    chk("shadow_rise",  64'(rise - k),    64'd13);
    chk("shadow_width", 64'(fall - rise), 64'd10);
    chk("shadow_miss",  64'(miss_cnt),    64'd1);
    chk("shadow_frame", 64'(frame_cnt),   64'd1);
    $display("retrigger: rise=+%0d width=%0d miss=%0d frame=%0d", rise - k, fall - rise, miss_cnt, frame_cnt);

    // en dropped 5 cycles into a 20-cycle pulse
    do_reset();
    del = 2; dur = 20; en = 1'b1;
    step();
    k = m; trig_in = 1'b1; dn = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m == k + 1) trig_in = 1'b0;
      if (m == k + 9) begin
        chk("abort_en_pulse_before", 64'(pulse_out), 64'd1);
        en = 1'b0;
      end
      if (m == k + 10) begin
        chk("abort_en_pulse", 64'(pulse_out), 64'd0);
        chk("abort_en_busy",  64'(busy),      64'd0);
      end
      if (done === 1'b1) dn++;
    end
    chk("abort_en_done",  64'(dn),        64'd0);
    chk("abort_en_frame", 64'(frame_cnt), 64'd0);
    $display("abort by en: done=%0d frame=%0d", dn, frame_cnt);

    // clr mid-pulse, with one miss recorded beforehand
    en = 1'b1;
    do_reset();
    step();
    k = m; trig_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (m == k + 1) trig_in = 1'b0;
      if (m == k + 7) trig_in = 1'b1;
      if (m == k + 8) trig_in = 1'b0;
      if (m == k + 12) begin
        chk("abort_clr_miss_before", 64'(miss_cnt),  64'd1);
        chk("abort_clr_pulse_before", 64'(pulse_out), 64'd1);
        clr = 1'b1;
      end
      if (m == k + 13) begin
        chk("abort_clr_pulse", 64'(pulse_out), 64'd0);
        chk("abort_clr_busy",  64'(busy),      64'd0);
        chk("abort_clr_done",  64'(done),      64'd0);
        chk("abort_clr_frame", 64'(frame_cnt), 64'd0);
        chk("abort_clr_miss",  64'(miss_cnt),  64'd0);
        clr = 1'b0;
      end
    end
    $display("abort by clr: pulse=%0d busy=%0d miss=%0d", pulse_out, busy, miss_cnt);

    // Maximum del/dur accepted; counters only count down
    do_reset();
    del = '1; dur = '1; hv_level = 8'h80; thhv = 8'h40; en = 1'b1;
    step();
    trig_in = 1'b1; step(); trig_in = 1'b0;
    repeat (20) step();
    chk("max_busy",  64'(busy),      64'd1);
    chk("max_pulse", 64'(pulse_out), 64'd0);
    en = 1'b0; step();
    chk("max_abort", 64'(busy), 64'd0);
    en = 1'b1;
    $display("max del/dur: busy after abort=%0d", busy);

    // miss_cnt saturation
    do_reset();
    del = 1; dur = 1; hv_level = 8'h10; thhv = 8'h40;
    for (int i = 0; i < 256; i++) begin
      trig_in = 1'b1; step(); trig_in = 1'b0; step();
    end
    repeat (4) step();
    chk("miss_sat", 64'(miss_cnt), 64'(MMAX));
    $display("miss saturation: 256 rejects -> miss=%0d", miss_cnt);

    // frame_cnt wrap
    do_reset();
    del = 0; dur = 1; hv_level = 8'h80; dn = 0;
    for (longint i = 0; i < FMOD + 1; i++) begin
      trig_in = 1'b1; step(); if (done === 1'b1) dn++;
      trig_in = 1'b0; step(); if (done === 1'b1) dn++;
    end
    repeat (4) begin step(); if (done === 1'b1) dn++; end
    chk("wrap_frame", 64'(frame_cnt), 64'd1);
    chk("wrap_done",  64'(dn),        64'(FMOD + 1));
    chk("wrap_miss",  64'(miss_cnt),  64'd0);
    $display("frame wrap: %0d frames -> frame=%0d", FMOD + 1, frame_cnt);

    // Randomised traffic against the event model
    do_reset();
    thhv = 8'h40; en = 1'b1; n_ev = 0; n_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      trig_in = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) del = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) dur = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) hv_level = 8'(8'h3C + $urandom_range(0, 8));
      en  = ($urandom_range(0, 59) != 0);
      clr = ($urandom_range(0, 799) == 0);
    end
    clr = 1'b0; trig_in = 1'b0; en = 1'b1;
    repeat (30) step();
    $display("random: %0d trigger events, %0d accepted, frame=%0d miss=%0d",
             n_ev, n_acc, frame_cnt, miss_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
